mux4_rr_sampler: RTL and testbench
==================================

Name: mux4_rr_sampler

Overview:
- Sequential front-end for a 4-channel, 8-bit selection datapath.
- Arbitrates four requesting sources, registers the winning channel index on `sel`, and captures that channel's word into an output holding register.
- Presents the captured word downstream with a valid/ready handshake.
- `sel` is exported so a shared external 4:1 datapath mux can be steered in lock-step with the internal capture.

Parameters:
- WIDTH, 8, data width of every input channel and of `out`.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority (channel 0 highest, channel 3 lowest).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-channel request; req[i] high means in_i holds a valid word.
- in0  input  WIDTH  channel 0 data.
- in1  input  WIDTH  channel 1 data.
- in2  input  WIDTH  channel 2 data.
- in3  input  WIDTH  channel 3 data.
- ack  output  4  one-cycle pulse on the channel whose word was captured.
- sel  output  2  registered grant index; holds the last granted channel.
- out  output  WIDTH  captured word (holding register).
- out_valid  output  1  `out` holds an unconsumed word.
- out_ready  input  1  downstream accepts `out` when out_valid && out_ready.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, ptr=0, sel=0, out=0, out_valid=0, ack=0, busy=0.
- rst has priority over every other event, including mid-CAPT and mid-HOLD. A word held in `out` is discarded and no ack is issued.
- FSM states: IDLE, CAPT, HOLD.
- IDLE, req==0:
  - Remain in IDLE.
  - out_ready is ignored.
- IDLE, req!=0:
  - Winner with RR_EN=1: the first set req bit scanning ptr, ptr+1, … mod 4.
  - Winner with RR_EN=0: the lowest set index.
  - sel<=winner; state<=CAPT.
- CAPT (exactly one cycle):
  - out<=in[sel]; out_valid<=1; ack[sel]<=1 (registered, so ack and out_valid rise on the same edge); state<=HOLD.
  - Capture happens even if req[sel] dropped during CAPT; requesters must hold req and data stable until ack.
- HOLD:
  - ack returns to 0 after one cycle.
  - out and sel are held stable while out_valid=1 && out_ready=0.
  - On out_valid && out_ready: out_valid<=0; ptr<=(sel+1) mod 4; state<=IDLE.
  - ptr wraps 3→0.
  - The out value is retained after the handshake; only out_valid clears.
- Latency: req seen in IDLE at edge N → sel updated after edge N → out/out_valid/ack high after edge N+1.
- Throughput: at most one word per 3 cycles with out_ready tied high.
- A requester that still has req high in the cycle after its ack is treated as presenting a new word and re-arbitrated. Under RR_EN=1 it is last in order.
- Simultaneous events:
  - Requests arriving during CAPT/HOLD wait until IDLE.
  - A handshake in HOLD and a new req on the same edge: the new req is arbitrated in the following IDLE cycle, using the updated ptr.
- busy = (state != IDLE).
- All outputs are registered except busy, which is decoded from the state register.
- No combinational path from req or in* to any output.

Test Plan:
1. Reset then single request: rst 2 cycles; req=4'b0100, in2=8'hA5, out_ready=1.
   - sel=2 one cycle after the grant edge.
   - Next cycle: out=8'hA5, out_valid=1, ack=4'b0100.
   - Following cycle: out_valid=0, IDLE.
2. Round-robin fairness: RR_EN=1; req=4'b1111 held; in0..in3=8'h10,8'h21,8'h32,8'h43; out_ready=1.
   - Captured sequence 10,21,32,43,10.
   - ack order bit0,1,2,3,0; ptr wraps 3→0.
3. Fixed priority: RR_EN=0; req=4'b1010 held.
   - Every capture is channel 1 (out=in1, ack=4'b0010); channel 3 is never served while req[1]=1.
4. Backpressure: capture in0=8'h5A; out_ready=0 for 5 cycles while in0 changes to 8'hFF and req=4'b1111.
   - out stays 8'h5A, out_valid=1, sel and ack stable/0.
   - After out_ready=1 for one cycle: out_valid=0, next grant = ptr=1.
5. Reset mid-operation: assert rst in the CAPT cycle, and separately in the HOLD cycle with out_valid=1.
   - Next cycle in both cases: out=0, out_valid=0, ack=0, sel=0, busy=0, ptr=0.
   - Subsequent req=4'b0110 grants channel 1.
6. Idle handshake: req=0, out_ready=1 for 10 cycles.
   - out_valid, ack, and busy remain 0; no state change.

Source files
------------

// File: rtl/mux4_rr_sampler_if.sv
// Bundle of request/data inputs and captured-word outputs of the 4-channel sampler.
// master drives requests, data and out_ready; slave is the sampler itself.
interface mux4_rr_sampler_if #(
   parameter int WIDTH = 8
);
   logic [3:0]       req;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [WIDTH-1:0] in3;
   logic [3:0]       ack;
   logic [1:0]       sel;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   modport master (
      output req, in0, in1, in2, in3, out_ready,
      input  ack, sel, out, out_valid, busy
   );

   modport slave (
      input  req, in0, in1, in2, in3, out_ready,
      output ack, sel, out, out_valid, busy
   );
endinterface

// File: rtl/mux4_rr_sampler.sv
// Arbitrates four 8-bit channels, registers the grant on sel, captures the
// winning word into a holding register and offers it with valid/ready.
module mux4_rr_sampler #(
   parameter int WIDTH = 8,
   parameter bit RR_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   mux4_rr_sampler_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAPT = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       sel_q, sel_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic [3:0]       ack_q, ack_d;

   logic [WIDTH-1:0] in_arr [4];
   logic [1:0]       base;
   logic [1:0]       idx;
   logic [1:0]       winner;
   logic             found;

   assign in_arr[0] = bus.in0;
   assign in_arr[1] = bus.in1;
   assign in_arr[2] = bus.in2;
   assign in_arr[3] = bus.in3;

   // Scan starts at ptr for round-robin, at channel 0 for fixed priority.
   always_comb begin
      base   = RR_EN ? ptr_q : 2'd0;
      idx    = base;
      winner = base;
      found  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = base + 2'(k);
         if (!found && bus.req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      ack_d       = 4'b0000;
      case (state_q)
         IDLE: begin
            if (found) begin
               sel_d   = winner;
               state_d = CAPT;
            end
         end
         CAPT: begin
            out_d        = in_arr[sel_q];
            out_valid_d  = 1'b1;
            ack_d[sel_q] = 1'b1;
            state_d      = HOLD;
         end
         HOLD: begin
            // out is kept after the handshake; only the valid flag drops.
            if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
               ptr_d       = sel_q + 2'd1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= 2'd0;
         sel_q       <= 2'd0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         ack_q       <= 4'b0000;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         ack_q       <= ack_d;
      end
   end

   assign bus.ack       = ack_q;
   assign bus.sel       = sel_q;
   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux4_rr_sampler.sv
// Self-checking bench: one round-robin and one fixed-priority instance, a table
// of single-word grants, hand-written corner sequences and an ack scoreboard.
module tb_mux4_rr_sampler;

   typedef struct packed {
      logic [3:0] ack;
      logic [7:0] data;
   } exp_t;

   typedef struct packed {
      bit         fp;
      logic [3:0] req;
      logic [3:0] exp_ack;
      logic [7:0] exp_out;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q_rr[$];
   exp_t q_fp[$];

   always #5 clk = ~clk;

   mux4_rr_sampler_if #(.WIDTH(8)) bus_rr ();
   mux4_rr_sampler_if #(.WIDTH(8)) bus_fp ();

   mux4_rr_sampler #(.WIDTH(8), .RR_EN(1'b1)) u_rr (.clk(clk), .rst(rst), .bus(bus_rr.slave));
   mux4_rr_sampler #(.WIDTH(8), .RR_EN(1'b0)) u_fp (.clk(clk), .rst(rst), .bus(bus_fp.slave));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic chk_idle_rr(input string tag);
      chk({tag, "_out"}, {24'd0, bus_rr.out}, 32'h0);
      chk({tag, "_valid"}, {31'd0, bus_rr.out_valid}, 32'd0);
      chk({tag, "_ack"}, {28'd0, bus_rr.ack}, 32'd0);
      chk({tag, "_sel"}, {30'd0, bus_rr.sel}, 32'd0);
      chk({tag, "_busy"}, {31'd0, bus_rr.busy}, 32'd0);
   endtask

   // Every ack pulse is one transaction; it must match the oldest expectation.
   always @(negedge clk) begin
      if (bus_rr.ack !== 4'b0000) begin
         if (q_rr.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rr_unexpected_ack: got ack=%b out=%h, expected no capture", bus_rr.ack, bus_rr.out);
         end else begin
            exp_t e;
            e = q_rr.pop_front();
            $display("rr capture: ack=%b out=%h (expected ack=%b out=%h)", bus_rr.ack, bus_rr.out, e.ack, e.data);
            chk("rr_ack", {28'd0, bus_rr.ack}, {28'd0, e.ack});
            chk("rr_out", {24'd0, bus_rr.out}, {24'd0, e.data});
            chk("rr_valid", {31'd0, bus_rr.out_valid}, 32'd1);
         end
      end
      if (bus_fp.ack !== 4'b0000) begin
         if (q_fp.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fp_unexpected_ack: got ack=%b out=%h, expected no capture", bus_fp.ack, bus_fp.out);
         end else begin
            exp_t e;
            e = q_fp.pop_front();
            $display("fp capture: ack=%b out=%h (expected ack=%b out=%h)", bus_fp.ack, bus_fp.out, e.ack, e.data);
            chk("fp_ack", {28'd0, bus_fp.ack}, {28'd0, e.ack});
            chk("fp_out", {24'd0, bus_fp.out}, {24'd0, e.data});
            chk("fp_valid", {31'd0, bus_fp.out_valid}, 32'd1);
         end
      end
   end

   vec_t vecs [15];

   initial begin
      vecs[0]  = '{fp: 1'b0, req: 4'b1111, exp_ack: 4'b0001, exp_out: 8'h10};
      vecs[1]  = '{fp: 1'b0, req: 4'b1111, exp_ack: 4'b0010, exp_out: 8'h21};
      vecs[2]  = '{fp: 1'b0, req: 4'b1111, exp_ack: 4'b0100, exp_out: 8'h32};
      vecs[3]  = '{fp: 1'b0, req: 4'b1111, exp_ack: 4'b1000, exp_out: 8'h43};
      vecs[4]  = '{fp: 1'b0, req: 4'b1111, exp_ack: 4'b0001, exp_out: 8'h10};
      vecs[5]  = '{fp: 1'b0, req: 4'b1001, exp_ack: 4'b1000, exp_out: 8'h43};
      vecs[6]  = '{fp: 1'b0, req: 4'b0110, exp_ack: 4'b0010, exp_out: 8'h21};
      vecs[7]  = '{fp: 1'b0, req: 4'b0011, exp_ack: 4'b0001, exp_out: 8'h10};
      vecs[8]  = '{fp: 1'b0, req: 4'b0001, exp_ack: 4'b0001, exp_out: 8'h10};
      vecs[9]  = '{fp: 1'b1, req: 4'b1010, exp_ack: 4'b0010, exp_out: 8'h21};
      vecs[10] = '{fp: 1'b1, req: 4'b1010, exp_ack: 4'b0010, exp_out: 8'h21};
      vecs[11] = '{fp: 1'b1, req: 4'b1010, exp_ack: 4'b0010, exp_out: 8'h21};
      vecs[12] = '{fp: 1'b1, req: 4'b1000, exp_ack: 4'b1000, exp_out: 8'h43};
      vecs[13] = '{fp: 1'b1, req: 4'b1100, exp_ack: 4'b0100, exp_out: 8'h32};
      vecs[14] = '{fp: 1'b1, req: 4'b1111, exp_ack: 4'b0001, exp_out: 8'h10};

      bus_rr.req = 4'b0000; bus_rr.out_ready = 1'b1;
      bus_rr.in0 = 8'h10; bus_rr.in1 = 8'h21; bus_rr.in2 = 8'h32; bus_rr.in3 = 8'h43;
      bus_fp.req = 4'b0000; bus_fp.out_ready = 1'b1;
      bus_fp.in0 = 8'h10; bus_fp.in1 = 8'h21; bus_fp.in2 = 8'h32; bus_fp.in3 = 8'h43;

      // Reset then a single request on channel 2.
      do_reset();
      chk_idle_rr("reset");
      bus_rr.req = 4'b0100;
      bus_rr.in2 = 8'hA5;
      q_rr.push_back('{ack: 4'b0100, data: 8'hA5});
      tick();
      chk("t1_sel", {30'd0, bus_rr.sel}, 32'd2);
      chk("t1_busy_capt", {31'd0, bus_rr.busy}, 32'd1);
      chk("t1_valid_early", {31'd0, bus_rr.out_valid}, 32'd0);
      bus_rr.req = 4'b0000;
      tick();
      chk("t1_out", {24'd0, bus_rr.out}, 32'hA5);
      chk("t1_ack", {28'd0, bus_rr.ack}, 32'h4);
      tick();
      chk("t1_valid_clear", {31'd0, bus_rr.out_valid}, 32'd0);
      chk("t1_busy_idle", {31'd0, bus_rr.busy}, 32'd0);
      chk("t1_out_retained", {24'd0, bus_rr.out}, 32'hA5);
      bus_rr.in2 = 8'h32;

      // Table of single-word grants on both arbitration flavours.
      do_reset();
      for (int i = 0; i < 15; i++) begin
         if (vecs[i].fp) begin
            bus_rr.req = 4'b0000;
            bus_fp.req = vecs[i].req;
            q_fp.push_back('{ack: vecs[i].exp_ack, data: vecs[i].exp_out});
         end else begin
            bus_fp.req = 4'b0000;
            bus_rr.req = vecs[i].req;
            q_rr.push_back('{ack: vecs[i].exp_ack, data: vecs[i].exp_out});
         end
         tick();
         tick();
         tick();
         if (vecs[i].fp) begin
            chk($sformatf("vec%0d_fp_out", i), {24'd0, bus_fp.out}, {24'd0, vecs[i].exp_out});
            chk($sformatf("vec%0d_fp_busy", i), {31'd0, bus_fp.busy}, 32'd0);
         end else begin
            chk($sformatf("vec%0d_rr_out", i), {24'd0, bus_rr.out}, {24'd0, vecs[i].exp_out});
            chk($sformatf("vec%0d_rr_busy", i), {31'd0, bus_rr.busy}, 32'd0);
         end
      end
      bus_rr.req = 4'b0000;
      bus_fp.req = 4'b0000;

      // Backpressure: held word must not follow changing input or new requests.
      do_reset();
      bus_rr.req = 4'b0001;
      bus_rr.in0 = 8'h5A;
      bus_rr.out_ready = 1'b0;
      q_rr.push_back('{ack: 4'b0001, data: 8'h5A});
      tick();
      tick();
      bus_rr.in0 = 8'hFF;
      bus_rr.req = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("bp%0d_out", c), {24'd0, bus_rr.out}, 32'h5A);
         chk($sformatf("bp%0d_valid", c), {31'd0, bus_rr.out_valid}, 32'd1);
         chk($sformatf("bp%0d_sel", c), {30'd0, bus_rr.sel}, 32'd0);
         chk($sformatf("bp%0d_ack", c), {28'd0, bus_rr.ack}, 32'd0);
      end
      bus_rr.out_ready = 1'b1;
      tick();
      chk("bp_valid_clear", {31'd0, bus_rr.out_valid}, 32'd0);
      chk("bp_busy_idle", {31'd0, bus_rr.busy}, 32'd0);
      q_rr.push_back('{ack: 4'b0010, data: 8'h21});
      tick();
      chk("bp_next_sel", {30'd0, bus_rr.sel}, 32'd1);
      bus_rr.req = 4'b0000;
      tick();
      tick();
      bus_rr.in0 = 8'h10;

      // Reset during CAPT, after first moving ptr to 2.
      do_reset();
      bus_rr.req = 4'b0010;
      q_rr.push_back('{ack: 4'b0010, data: 8'h21});
      tick(); tick(); tick();
      bus_rr.req = 4'b0010;
      tick();
      chk("rc_busy_capt", {31'd0, bus_rr.busy}, 32'd1);
      rst = 1'b1;
      bus_rr.req = 4'b0000;
      tick();
      rst = 1'b0;
      chk_idle_rr("rst_capt");
      bus_rr.req = 4'b0110;
      q_rr.push_back('{ack: 4'b0010, data: 8'h21});
      tick();
      chk("rc_grant_sel", {30'd0, bus_rr.sel}, 32'd1);
      bus_rr.req = 4'b0000;
      tick(); tick();

      // Reset during HOLD with a word pending (ptr is 2 again here).
      bus_rr.out_ready = 1'b0;
      bus_rr.req = 4'b0010;
      q_rr.push_back('{ack: 4'b0010, data: 8'h21});
      tick();
      bus_rr.req = 4'b0000;
      tick();
      tick();
      chk("rh_valid_pending", {31'd0, bus_rr.out_valid}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus_rr.out_ready = 1'b1;
      chk_idle_rr("rst_hold");
      bus_rr.req = 4'b0110;
      q_rr.push_back('{ack: 4'b0010, data: 8'h21});
      tick();
      chk("rh_grant_sel", {30'd0, bus_rr.sel}, 32'd1);
      bus_rr.req = 4'b0000;
      tick(); tick();

      // Idle with out_ready high: nothing may happen.
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("idle%0d_valid", c), {31'd0, bus_rr.out_valid}, 32'd0);
         chk($sformatf("idle%0d_ack", c), {28'd0, bus_rr.ack}, 32'd0);
         chk($sformatf("idle%0d_busy", c), {31'd0, bus_rr.busy}, 32'd0);
      end

      chk("rr_queue_drained", q_rr.size(), 32'd0);
      chk("fp_queue_drained", q_fp.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
